// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory slave with wait states and ERROR responses.
// Define AHB_MEM_SLAVE_RANGE_CHECK_EN to reject HADDR >= MEM_BYTES.
module ahb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int L     = $clog2(NB);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IW    = (AW > L) ? AW - L : 1;
  localparam int WORDS = MEM_BYTES / NB;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t r_state;
  state_t w_nstate;
  logic [3:0] r_cnt;
  logic [3:0] w_ncnt;
  logic [IW-1:0] r_idx;
  logic [NB-1:0] r_be;
  logic r_write;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic [L-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [NB-1:0] w_be;
  logic w_mis;
  logic w_big;
  logic w_illegal;
  logic w_open;
  logic w_accept;
  logic w_unused;

  assign w_off = L'(HADDR);
  assign w_idx = IW'(HADDR >> L);
  assign w_big = HSIZE > 3'(L);
  assign w_unused = ^{HTRANS[0], HADDR};

  always_comb begin
    w_be = '0;
    w_mis = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(w_off) &&
          b < int'(w_off) + (1 << HSIZE))
        w_be[b] = 1'b1;
    end
    for (int i = 0; i < L; i++) begin
      if (i < int'(HSIZE) && w_off[i])
        w_mis = 1'b1;
    end
  end

`ifdef AHB_MEM_SLAVE_RANGE_CHECK_EN
  assign w_illegal = w_big | w_mis |
                     (HADDR >= 32'(MEM_BYTES));
`else
  assign w_illegal = w_big | w_mis;
`endif

  // New address phases only land when the previous data phase is closing.
  assign w_open = (r_state == S_IDLE) ||
                  (r_state == S_LAST) ||
                  (r_state == S_ERR2);
  assign w_accept = HREADYIN & HSEL & HTRANS[1] & w_open;

  always_comb begin
    w_nstate = r_state;
    w_ncnt = r_cnt;
    unique case (r_state)
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_nstate = S_LAST;
          w_ncnt = 4'd0;
        end else begin
          w_ncnt = r_cnt - 4'd1;
        end
      end
      S_ERR1: w_nstate = S_ERR2;
      default: begin
        w_nstate = S_IDLE;
        w_ncnt = 4'd0;
        if (w_accept) begin
          if (w_illegal) begin
            w_nstate = S_ERR1;
          end else if (WS != 4'd0) begin
            w_nstate = S_WAIT;
            w_ncnt = WS;
          end else begin
            w_nstate = S_LAST;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt <= 4'd0;
      r_idx <= '0;
      r_be <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      if (w_accept) begin
        r_idx <= w_idx;
        r_be <= w_be;
        r_write <= HWRITE;
      end
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge HCLK) begin
    if (r_state == S_LAST && r_write) begin
      for (int b = 0; b < NB; b++) begin
        if (r_be[b])
          r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (r_state == S_LAST && !r_write) begin
      for (int b = 0; b < NB; b++) begin
        if (r_be[b])
          HRDATA[8*b +: 8] = r_mem[r_idx][8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((r_state == S_WAIT) ||
                       (r_state == S_ERR1));
  assign HRESP = {1'b0, (r_state == S_ERR1) ||
                        (r_state == S_ERR2)};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: two slaves on one bus (32-bit/0 waits, 64-bit/3 waits),
// driven by a pipelined master with a byte-level memory model.
`timescale 1ns/1ps
module tb_ahb_mem_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sel;
  logic sel0;
  logic sel1;
  logic [31:0] haddr;
  logic [1:0] htrans;
  logic hwrite;
  logic [2:0] hsize;
  logic [63:0] hwdata;
  logic [31:0] rd0;
  logic [63:0] rd1;
  logic rdy0;
  logic rdy1;
  logic [1:0] resp0;
  logic [1:0] resp1;
  logic [63:0] hrdata;
  logic hready;
  logic [1:0] hresp;

  assign sel0 = !sel;
  assign sel1 = sel;
  assign hrdata = sel ? rd1 : {32'b0, rd0};
  assign hready = sel ? rdy1 : rdy0;
  assign hresp = sel ? resp1 : resp0;

  ahb_mem_slave #(.DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HWDATA(hwdata[31:0]), .HRDATA(rd0), .HREADYIN(hready),
    .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_mem_slave #(.DATA_WIDTH(64), .MEM_BYTES(1024), .WAIT_STATES(3)) u1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel1), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HWDATA(hwdata), .HRDATA(rd1), .HREADYIN(hready),
    .HREADYOUT(rdy1), .HRESP(resp1));

  typedef struct {
    logic        wr;
    logic [1:0]  tr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } xfer_t;

  typedef struct {
    logic        wr;
    logic [63:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  xfer_t q_req[$];
  exp_t q_exp[$];
  logic [7:0] mdl [2][1024];
  int total = 0;
  int bad = 0;
  int dp_cycles;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void req(input logic [1:0] tr, input logic wr,
                              input logic [31:0] addr, input logic [2:0] size,
                              input logic [63:0] wdata);
    xfer_t x;
    x.tr = tr; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    q_req.push_back(x);
  endfunction

  function automatic exp_t predict(input int d, input xfer_t x);
    exp_t e;
    int nb, l, off, base, n;
    bit ill;
    nb = d ? 8 : 4;
    l = d ? 3 : 2;
    off = int'(x.addr % 32'(nb));
    ill = (int'(x.size) > l) || ((off % (1 << x.size)) != 0);
`ifdef AHB_MEM_SLAVE_RANGE_CHECK_EN
    if (x.addr >= 32'd1024) ill = 1'b1;
`endif
    e.wr = x.wr;
    e.rdata = '0;
    e.resp = ill ? 2'b01 : 2'b00;
    e.waits = ill ? 1 : (d ? 3 : 0);
    if (!ill) begin
      base = int'(x.addr % 32'd1024) - off;
      n = 1 << x.size;
      for (int b = off; b < off + n; b++) begin
        if (x.wr) mdl[d][base + b] = x.wdata[8*b +: 8];
        else e.rdata[8*b +: 8] = mdl[d][base + b];
      end
    end
    return e;
  endfunction

  task automatic run(input int d);
    xfer_t x;
    exp_t e;
    logic [63:0] dwd;
    int w;
    int guard;
    sel = d[0];
    dp_cycles = 0;
    dwd = '0;
    w = 0;
    guard = 0;
    while ((q_req.size() > 0 || q_exp.size() > 0) && guard < 200) begin
      guard++;
      if (q_req.size() > 0) begin
        haddr = q_req[0].addr;
        htrans = q_req[0].tr;
        hwrite = q_req[0].wr;
        hsize = q_req[0].size;
      end else begin
        htrans = 2'b00;
      end
      hwdata = dwd;
      @(negedge clk);
      if (q_exp.size() > 0) dp_cycles++;
      if (hready) begin
        if (q_exp.size() > 0) begin
          e = q_exp.pop_front();
          chk("resp", 64'(hresp), 64'(e.resp));
          chk("waits", 64'(w), 64'(e.waits));
          if (!e.wr) chk("rdata", hrdata, e.rdata);
        end
        if (q_req.size() > 0) begin
          x = q_req.pop_front();
          q_exp.push_back(predict(d, x));
          dwd = x.wdata;
          w = 0;
        end
      end else if (q_exp.size() > 0) begin
        w++;
        chk("wait_resp", 64'(hresp), 64'(q_exp[0].resp));
      end
      @(posedge clk);
      #1;
    end
    htrans = 2'b00;
    chk("run_bound", 64'(guard < 200), 64'd1);
    q_req.delete();
    q_exp.delete();
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    haddr = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize = 3'd2;
    hwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy0", 64'(rdy0), 64'd1);
    chk("rst_resp0", 64'(resp0), 64'd0);
    chk("rst_rd0", 64'(rd0), 64'd0);
    chk("rst_rdy1", 64'(rdy1), 64'd1);
    chk("rst_resp1", 64'(resp1), 64'd0);
    chk("rst_rd1", rd1, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 32-bit, zero waits: back-to-back write then read, sub-word lanes
    req(2'b10, 1'b1, 32'h10, 3'd2, 64'hDEADBEEF);
    req(2'b10, 1'b0, 32'h10, 3'd2, 64'h0);
    req(2'b10, 1'b1, 32'h12, 3'd1, 64'h1234_0000);
    req(2'b10, 1'b1, 32'h11, 3'd0, 64'h0000_7700);
    req(2'b10, 1'b0, 32'h10, 3'd2, 64'h0);
    req(2'b10, 1'b0, 32'h13, 3'd0, 64'h0);
    req(2'b10, 1'b0, 32'h12, 3'd1, 64'h0);
    run(0);

    // misaligned and oversize accesses, then confirm data untouched
    req(2'b10, 1'b1, 32'h11, 3'd1, 64'h5555_5555);
    req(2'b10, 1'b0, 32'h10, 3'd2, 64'h0);
    req(2'b10, 1'b0, 32'h10, 3'd3, 64'h0);
    req(2'b10, 1'b1, 32'h12, 3'd2, 64'h6666_6666);
    req(2'b10, 1'b0, 32'h10, 3'd2, 64'h0);
    run(0);

    // out-of-range write: aliases or errors depending on build
    req(2'b10, 1'b1, 32'h000, 3'd2, 64'h1111_1111);
    req(2'b10, 1'b1, 32'h400, 3'd2, 64'hCAFE_F00D);
    req(2'b10, 1'b0, 32'h000, 3'd2, 64'h0);
    run(0);

    // 64-bit, three waits: byte lane merge
    req(2'b10, 1'b1, 32'h08, 3'd3, 64'h0123_4567_89AB_CDEF);
    req(2'b10, 1'b1, 32'h10, 3'd3, 64'h1010_2020_3030_4040);
    req(2'b10, 1'b1, 32'h18, 3'd3, 64'h5050_6060_7070_8080);
    req(2'b10, 1'b1, 32'h20, 3'd3, 64'h9090_A0A0_B0B0_C0C0);
    req(2'b10, 1'b1, 32'h0D, 3'd0, 64'h0000_AB00_0000_0000);
    req(2'b10, 1'b0, 32'h08, 3'd3, 64'h0);
    req(2'b10, 1'b1, 32'h0E, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    req(2'b10, 1'b0, 32'h0C, 3'd2, 64'h0);
    run(1);

    // four back-to-back reads: 4 x (3+1) data-phase cycles
    req(2'b10, 1'b0, 32'h08, 3'd3, 64'h0);
    req(2'b11, 1'b0, 32'h10, 3'd3, 64'h0);
    req(2'b11, 1'b0, 32'h18, 3'd3, 64'h0);
    req(2'b11, 1'b0, 32'h20, 3'd3, 64'h0);
    run(1);
    chk("burst_cycles", 64'(dp_cycles), 64'd16);

    // reset during the second wait cycle of a write
    sel = 1'b1;
    haddr = 32'h20;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize = 3'd3;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    chk("rst_mid_busy", 64'(hready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy", 64'(hready), 64'd1);
    chk("rst_mid_resp", 64'(hresp), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    req(2'b10, 1'b0, 32'h20, 3'd3, 64'h0);
    run(1);

    @(negedge clk);
    chk("idle_rdy", 64'(hready), 64'd1);
    chk("idle_resp", 64'(hresp), 64'd0);
    chk("idle_rdata", hrdata, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
